// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/bubble/flush controller.
// Imported by the controller top and its hazard comparator.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } stall_state_t;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam logic [1:0] JUMP_NONE = 2'b00;

  // One bundle of every per-stage control; field order fixes the packed layout.
  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic freeze_id_exe;
    logic freeze_exe_mem;
    logic freeze_mem_wb;
    logic bubble_id_exe;
    logic flush_if_id;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE       = ctrl_t'(7'b000_0000);
  localparam ctrl_t CTRL_FREEZE_ALL = ctrl_t'(7'b111_1100);
  localparam ctrl_t CTRL_REDIRECT   = ctrl_t'(7'b000_0011);
  localparam ctrl_t CTRL_LOAD_USE   = ctrl_t'(7'b110_0010);

  function automatic logic any_freeze(input ctrl_t c);
    return c.freeze_pc | c.freeze_if_id | c.freeze_id_exe |
           c.freeze_exe_mem | c.freeze_mem_wb;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_hazard.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load currently in EXE is about to write.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       exe_mem_to_reg,
  input  logic [4:0] exe_dest,
  input  logic       exe_dest_valid,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;
  logic dest_live;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign dest_live = exe_mem_to_reg & exe_dest_valid & (exe_dest != REG_ZERO);
  assign rs_hit    = (exe_dest == id_rs);
  assign rt_hit    = id_uses_rt & (exe_dest == id_rt);
  assign load_use  = dest_live & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Per-core pipeline stall controller: resolves cache wait, redirect and
// load-use hazards into freeze/bubble/flush controls plus perf counters.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             exe_mem_to_reg,
  input  logic [4:0]       exe_dest,
  input  logic             exe_dest_valid,
  input  logic [1:0]       exe_jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             freeze_id_exe,
  output logic             freeze_exe_mem,
  output logic             freeze_mem_wb,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [3:0]       FLUSH_LAST   = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0]      TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  stall_state_t     state_q, state_d;
  stall_state_t     ret_state_q, ret_state_d;
  logic [3:0]       flush_left_q, flush_left_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic  load_use;
  logic  mem_miss;
  ctrl_t ctrl;

  hazard_detect u_hazard (
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .exe_mem_to_reg (exe_mem_to_reg),
    .exe_dest       (exe_dest),
    .exe_dest_valid (exe_dest_valid),
    .load_use       (load_use)
  );

  // A request with ready in the same cycle is a zero-wait hit and never stalls.
  assign mem_miss = mem_req & ~mem_ready;

  // NOTE: every variable gets a default before the case, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    ctrl          = CTRL_NONE;
    state_d       = state_q;
    ret_state_d   = ret_state_q;
    flush_left_d  = flush_left_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    unique case (state_q)
      RUN: begin
        if (mem_miss) begin
          ctrl        = CTRL_FREEZE_ALL;
          state_d     = MEM_WAIT;
          ret_state_d = RUN;
        end else if (exe_jump != JUMP_NONE) begin
          ctrl         = CTRL_REDIRECT;
          flush_left_d = FLUSH_LAST;
          if (FLUSH_LAST != 4'd0) begin
            state_d = FLUSH;
          end
        end else if (load_use) begin
          ctrl = CTRL_LOAD_USE;
        end
      end

      FLUSH: begin
        // The slot in EXE is already a bubble, so exe_jump is not looked at here.
        if (mem_miss) begin
          ctrl        = CTRL_FREEZE_ALL;
          state_d     = MEM_WAIT;
          ret_state_d = FLUSH;
        end else begin
          ctrl         = CTRL_REDIRECT;
          flush_left_d = flush_left_q - 4'd1;
          if (flush_left_q == 4'd1) begin
            state_d = RUN;
          end
        end
      end

      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = ret_state_q;
          wait_cnt_d = 16'd0;
        end else begin
          ctrl = CTRL_FREEZE_ALL;
          if (wait_cnt_q == TIMEOUT_LAST) begin
            // Abandon the access and any pending bubbles; the error flag holds.
            mem_timeout_d = 1'b1;
            state_d       = RUN;
            flush_left_d  = 4'd0;
            wait_cnt_d    = 16'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (any_freeze(ctrl) && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (ctrl.flush_if_id && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values,
  // independent of the order the statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      ret_state_q   <= RUN;
      flush_left_q  <= 4'd0;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ret_state_q   <= ret_state_d;
      flush_left_q  <= flush_left_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign freeze_pc      = ctrl.freeze_pc;
  assign freeze_if_id   = ctrl.freeze_if_id;
  assign freeze_id_exe  = ctrl.freeze_id_exe;
  assign freeze_exe_mem = ctrl.freeze_exe_mem;
  assign freeze_mem_wb  = ctrl.freeze_mem_wb;
  assign bubble_id_exe  = ctrl.bubble_id_exe;
  assign flush_if_id    = ctrl.flush_if_id;
  assign mem_timeout    = mem_timeout_q;
  assign stall_count    = stall_count_q;
  assign flush_count    = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: two instances (default and short-timeout /
// narrow-counter) driven in parallel and checked against a behavioural model.
module tb_pipeline_stall_ctrl;

  // {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb, bubble, flush}
  localparam logic [6:0] L_NONE   = 7'b000_0000;
  localparam logic [6:0] L_FREEZE = 7'b111_1100;
  localparam logic [6:0] L_BUBBLE = 7'b000_0011;
  localparam logic [6:0] L_LDUSE  = 7'b110_0010;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, exe_dest;
  logic       id_uses_rt, exe_mem_to_reg, exe_dest_valid;
  logic [1:0] exe_jump;
  logic       mem_req, mem_ready;

  logic        fp_a, fi_a, fe_a, fm_a, fw_a, bb_a, fl_a, to_a;
  logic [31:0] sc_a, fc_a;
  logic        fp_b, fi_b, fe_b, fm_b, fw_b, bb_b, fl_b, to_b;
  logic [2:0]  sc_b, fc_b;

  pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(255), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .exe_mem_to_reg(exe_mem_to_reg), .exe_dest(exe_dest), .exe_dest_valid(exe_dest_valid),
    .exe_jump(exe_jump), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(fp_a), .freeze_if_id(fi_a), .freeze_id_exe(fe_a), .freeze_exe_mem(fm_a),
    .freeze_mem_wb(fw_a), .bubble_id_exe(bb_a), .flush_if_id(fl_a), .mem_timeout(to_a),
    .stall_count(sc_a), .flush_count(fc_a)
  );

  pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .exe_mem_to_reg(exe_mem_to_reg), .exe_dest(exe_dest), .exe_dest_valid(exe_dest_valid),
    .exe_jump(exe_jump), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(fp_b), .freeze_if_id(fi_b), .freeze_id_exe(fe_b), .freeze_exe_mem(fm_b),
    .freeze_mem_wb(fw_b), .bubble_id_exe(bb_b), .flush_if_id(fl_b), .mem_timeout(to_b),
    .stall_count(sc_b), .flush_count(fc_b)
  );

  logic [6:0]  act_ctrl  [2];
  logic [63:0] act_stall [2];
  logic [63:0] act_flush [2];
  logic        act_to    [2];
  assign act_ctrl[0]  = {fp_a, fi_a, fe_a, fm_a, fw_a, bb_a, fl_a};
  assign act_ctrl[1]  = {fp_b, fi_b, fe_b, fm_b, fw_b, bb_b, fl_b};
  assign act_stall[0] = 64'(sc_a);
  assign act_stall[1] = 64'(sc_b);
  assign act_flush[0] = 64'(fc_a);
  assign act_flush[1] = 64'(fc_b);
  assign act_to[0]    = to_a;
  assign act_to[1]    = to_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: pending bubbles, an outstanding-miss flag with its
  // elapsed length, the sticky error and plain integer counters.
  typedef struct {
    bit     waiting;
    int     wait_len;
    int     owed;
    bit     timeout;
    longint stalls;
    longint flushes;
  } model_t;

  localparam int FC [2] = '{2, 3};
  localparam int TO [2] = '{255, 4};
  localparam int CW [2] = '{32, 3};

  model_t m [2];
  bit     model_valid = 1'b0;

  function automatic bit load_use_exp();
    return exe_mem_to_reg && exe_dest_valid && (exe_dest != 5'd0) &&
           ((exe_dest == id_rs) || (id_uses_rt && (exe_dest == id_rt)));
  endfunction

  function automatic logic [6:0] exp_ctrl(input model_t s);
    if (s.waiting)                   return mem_ready ? L_NONE : L_FREEZE;
    if (mem_req && !mem_ready)       return L_FREEZE;
    if (s.owed > 0 || exe_jump != 0) return L_BUBBLE;
    if (load_use_exp())              return L_LDUSE;
    return L_NONE;
  endfunction

  function automatic model_t model_step(input model_t s, input int k);
    model_t     n;
    logic [6:0] e;
    longint     cmax;
    n    = s;
    e    = exp_ctrl(s);
    cmax = (longint'(1) << CW[k]) - 1;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    if ((|e[6:2]) && n.stalls < cmax) n.stalls++;
    if (e[0] && n.flushes < cmax)     n.flushes++;
    if (s.waiting) begin
      if (mem_ready) begin
        n.waiting  = 0;
        n.wait_len = 0;
      end else begin
        n.wait_len++;
        if (n.wait_len >= TO[k]) begin
          n.timeout  = 1;
          n.waiting  = 0;
          n.owed     = 0;
          n.wait_len = 0;
        end
      end
    end else if (mem_req && !mem_ready) begin
      n.waiting  = 1;
      n.wait_len = 0;
    end else if (s.owed > 0) begin
      n.owed--;
    end else if (exe_jump != 0) begin
      n.owed = FC[k] - 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) m[k] = model_step(m[k], k);
    if (rst) model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d ctrl", k),        64'(act_ctrl[k]), 64'(exp_ctrl(m[k])));
        check($sformatf("u%0d mem_timeout", k), 64'(act_to[k]),   64'(m[k].timeout));
        check($sformatf("u%0d stall_count", k), act_stall[k],     64'(m[k].stalls));
        check($sformatf("u%0d flush_count", k), act_flush[k],     64'(m[k].flushes));
      end
    end
  end

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    exe_mem_to_reg = 1'b0; exe_dest = 5'd0; exe_dest_valid = 1'b0;
    exe_jump = 2'b00; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_use_on(input logic [4:0] r);
    exe_mem_to_reg = 1'b1; exe_dest_valid = 1'b1; exe_dest = r; id_rs = r;
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  int frz;

  initial begin
    idle();
    rst = 1'b1;
    to_pos();
    to_pos();
    rst = 1'b0;
    @(negedge clk);
    check("rst ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    check("rst stall_count", act_stall[0], 64'd0);
    check("rst flush_count", act_flush[0], 64'd0);
    check("rst mem_timeout", 64'(to_a), 64'd0);
    to_pos();

    // load-use via rs, then r0 dependency that must not stall
    load_use_on(5'd5);
    @(negedge clk); check("ldu rs ctrl", 64'(act_ctrl[0]), 64'(L_LDUSE));
    to_pos();
    exe_dest = 5'd0; id_rs = 5'd0;
    @(negedge clk); check("ldu r0 ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    check("ldu stall_count", act_stall[0], 64'd1);
    to_pos();
    // load-use via rt, then the same with id_uses_rt low
    exe_dest = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
    @(negedge clk); check("ldu rt ctrl", 64'(act_ctrl[0]), 64'(L_LDUSE));
    to_pos();
    id_uses_rt = 1'b0;
    @(negedge clk); check("ldu rt unused ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    check("ldu2 stall_count", act_stall[0], 64'd2);
    to_pos();

    // zero-wait hit, then a miss held five cycles before ready
    idle();
    mem_req = 1'b1; mem_ready = 1'b1;
    @(negedge clk); check("hit ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    to_pos();
    mem_ready = 1'b0;
    frz = 0;
    repeat (5) begin
      @(negedge clk);
      if (act_ctrl[0] == L_FREEZE) frz++;
      to_pos();
    end
    check("miss freeze cycles", 64'(frz), 64'd5);
    mem_ready = 1'b1;
    @(negedge clk); check("miss ready ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    check("miss stall_count", act_stall[0], 64'd7);
    to_pos();
    idle();
    load_use_on(5'd9);
    @(negedge clk); check("ldu3 ctrl", 64'(act_ctrl[0]), 64'(L_LDUSE));
    to_pos();
    idle();
    @(negedge clk);
    check("stall_count after", act_stall[0], 64'd8);
    check("narrow stall_count saturated", act_stall[1], 64'd7);
    check("short timeout flag", 64'(to_b), 64'd1);
    check("long timeout flag", 64'(to_a), 64'd0);
    to_pos();

    rst = 1'b1;
    to_pos();
    rst = 1'b0;
    @(negedge clk);
    check("rst2 stall_count", act_stall[0], 64'd0);
    check("rst2 clears timeout", 64'(to_b), 64'd0);
    to_pos();

    // redirect, with a second jump during the bubble that must be ignored
    exe_jump = 2'b01;
    @(negedge clk); check("redir ctrl", 64'(act_ctrl[0]), 64'(L_BUBBLE));
    to_pos();
    exe_jump = 2'b10;
    @(negedge clk); check("flush ctrl", 64'(act_ctrl[0]), 64'(L_BUBBLE));
    to_pos();
    exe_jump = 2'b00;
    @(negedge clk); check("after flush ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    check("flush_count", act_flush[0], 64'd2);
    to_pos();
    to_pos();

    // miss in the second bubble cycle; the bubble is delivered after the return
    exe_jump = 2'b01;
    @(negedge clk); check("redir2 ctrl", 64'(act_ctrl[0]), 64'(L_BUBBLE));
    to_pos();
    exe_jump = 2'b00; mem_req = 1'b1; mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); check("flush miss ctrl", 64'(act_ctrl[0]), 64'(L_FREEZE));
      to_pos();
    end
    mem_ready = 1'b1;
    @(negedge clk); check("flush miss ready ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    to_pos();
    idle();
    @(negedge clk); check("resumed bubble ctrl", 64'(act_ctrl[0]), 64'(L_BUBBLE));
    to_pos();
    @(negedge clk); check("back to run ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    check("flush_count 2", act_flush[0], 64'd4);
    check("stall_count 2", act_stall[0], 64'd3);
    to_pos();

    // priority: miss beats redirect beats load-use
    mem_req = 1'b1; exe_jump = 2'b01; load_use_on(5'd4);
    @(negedge clk); check("prio miss ctrl", 64'(act_ctrl[0]), 64'(L_FREEZE));
    to_pos();
    idle();
    mem_req = 1'b1; mem_ready = 1'b1;
    @(negedge clk); check("prio exit ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    to_pos();
    idle();
    exe_jump = 2'b11; load_use_on(5'd4);
    @(negedge clk); check("prio redir ctrl", 64'(act_ctrl[0]), 64'(L_BUBBLE));
    to_pos();
    idle();
    repeat (3) to_pos();

    // timeout on the short instance
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (5) begin
      @(negedge clk); check("to wait ctrl", 64'(act_ctrl[1]), 64'(L_FREEZE));
      to_pos();
    end
    mem_req = 1'b0;
    @(negedge clk);
    check("to run ctrl", 64'(act_ctrl[1]), 64'(L_NONE));
    check("to flag", 64'(to_b), 64'd1);
    check("long still waiting", 64'(act_ctrl[0]), 64'(L_FREEZE));
    to_pos();
    mem_ready = 1'b1;
    @(negedge clk); check("long exit ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    to_pos();
    idle();
    repeat (3) to_pos();
    @(negedge clk); check("to sticky", 64'(to_b), 64'd1);
    to_pos();

    // reset in the middle of a flush
    exe_jump = 2'b01;
    to_pos();
    exe_jump = 2'b00; rst = 1'b1;
    to_pos();
    rst = 1'b0;
    @(negedge clk);
    check("rst flush ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    check("rst flush flush_count", act_flush[0], 64'd0);
    check("rst flush timeout", 64'(to_b), 64'd0);
    to_pos();

    // reset in the middle of a cache wait
    mem_req = 1'b1; mem_ready = 1'b0;
    to_pos();
    rst = 1'b1;
    to_pos();
    rst = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    check("rst wait ctrl", 64'(act_ctrl[0]), 64'(L_NONE));
    check("rst wait stall_count", act_stall[0], 64'd0);
    to_pos();
    to_pos();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
